// File: rtl/cpu_mem_loader_pkg.sv
// Shared constants, opcode and FSM encodings for the CPU memory loader.
package cpu_mem_loader_pkg;

   localparam int unsigned ADDR_W        = 64;
   localparam int unsigned DATA_W        = 64;
   localparam int unsigned IDATA_W       = 32;
   localparam int unsigned STEP_W        = 8;
   localparam int unsigned CNT_W_DEF     = 16;
   localparam int unsigned IMEM_STEP_DEF = 4;
   localparam int unsigned DMEM_STEP_DEF = 8;

   typedef enum logic [1:0] {
      OP_LOAD_IMEM = 2'b00,
      OP_LOAD_DMEM = 2'b01,
      OP_DUMP_DMEM = 2'b10,
      OP_SET_RUN   = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_RD_REQ  = 3'd2,
      ST_RD_WAIT = 3'd3,
      ST_RD_OUT  = 3'd4
   } state_e;

endpackage

// File: rtl/cpu_mem_loader_addr_gen.sv
// Current byte address and remaining-word counter for one loader command.
module cpu_mem_loader_addr_gen
   import cpu_mem_loader_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_base,
   input  logic [CNT_W-1:0]  i_count,
   input  logic              i_advance,
   input  logic [STEP_W-1:0] i_step,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_last
);

   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_remaining;

   // Load on command accept, step per transferred word; address wraps mod 2^64.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr      <= '0;
         r_remaining <= '0;
      end else if (i_load) begin
         r_addr      <= i_base;
         r_remaining <= i_count;
      end else if (i_advance) begin
         r_addr      <= r_addr + ADDR_W'(i_step);
         r_remaining <= r_remaining - CNT_W'(1);
      end
   end

   assign o_addr = r_addr;
   assign o_last = (r_remaining == CNT_W'(1));

endmodule

// File: rtl/cpu_mem_loader.sv
// Host command decoder driving the CPU IMEM/DMEM external ports and cpu enable.
module cpu_mem_loader
   import cpu_mem_loader_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned IMEM_STEP = IMEM_STEP_DEF,
   parameter int unsigned DMEM_STEP = DMEM_STEP_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [ADDR_W-1:0]  cmd_base,
   input  logic [CNT_W-1:0]   cmd_count,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_last,
   output logic               done,
   output logic               err,
   output logic               cpu_enable,
   output logic [ADDR_W-1:0]  addr_ext,
   output logic               wen_ext,
   output logic               ren_ext,
   output logic [IDATA_W-1:0] wdata_ext,
   output logic [ADDR_W-1:0]  addr_ext_2,
   output logic               wen_ext_2,
   output logic               ren_ext_2,
   output logic [DATA_W-1:0]  wdata_ext_2,
   input  logic [DATA_W-1:0]  rdata_ext_2
);

   state_e            r_state;
   state_e            w_state_nxt;
   op_e               r_op;
   op_e               w_cmd_op;
   logic              r_done;
   logic              r_err;
   logic              r_cpu_enable;
   logic [DATA_W-1:0] r_out_data;
   logic              w_accept;
   logic              w_advance;
   logic              w_finish;
   logic              w_set_err;
   logic              w_capture;
   logic              w_last;
   logic              w_load_imem;
   logic              w_load_dmem;
   logic [ADDR_W-1:0] w_cur_addr;
   logic [STEP_W-1:0] w_step;

   assign w_cmd_op = op_e'(cmd_op);
   assign w_step   = (r_op == OP_LOAD_IMEM) ? STEP_W'(IMEM_STEP) : STEP_W'(DMEM_STEP);

   cpu_mem_loader_addr_gen #(
      .CNT_W (CNT_W)
   ) u_loader_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_accept),
      .i_base    (cmd_base),
      .i_count   (cmd_count),
      .i_advance (w_advance),
      .i_step    (w_step),
      .o_addr    (w_cur_addr),
      .o_last    (w_last)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state and per-cycle control strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_advance   = 1'b0;
      w_finish    = 1'b0;
      w_set_err   = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               w_accept = 1'b1;
               if (w_cmd_op == OP_SET_RUN || cmd_count == '0) w_finish = 1'b1;
               else if (w_cmd_op == OP_DUMP_DMEM)             w_state_nxt = ST_RD_REQ;
               else                                           w_state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (in_valid) begin
               w_advance = 1'b1;
               if (w_last) begin
                  w_finish    = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else if (in_last) begin
                  w_set_err   = 1'b1;
                  w_finish    = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_RD_REQ:  w_state_nxt = ST_RD_WAIT;
         ST_RD_WAIT: begin
            w_capture   = 1'b1;
            w_state_nxt = ST_RD_OUT;
         end
         ST_RD_OUT: begin
            if (out_ready) begin
               w_advance = 1'b1;
               if (w_last) begin
                  w_finish    = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_RD_REQ;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Command latch, completion pulse, sticky error and cpu enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op         <= OP_LOAD_IMEM;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_cpu_enable <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_accept) begin
            r_op         <= w_cmd_op;
            r_err        <= 1'b0;
            r_cpu_enable <= (w_cmd_op == OP_SET_RUN) ? cmd_base[0] : 1'b0;
         end else if (w_set_err) begin
            r_err <= 1'b1;
         end
      end
   end

   // Dump word holding register, stable for the whole RD_OUT stall.
   always_ff @(posedge clk) begin
      if (rst)            r_out_data <= '0;
      else if (w_capture) r_out_data <= rdata_ext_2;
   end

   // Memory-port strobes are combinational so a word is written in its handshake cycle.
   assign w_load_imem = (r_state == ST_LOAD) && (r_op == OP_LOAD_IMEM);
   assign w_load_dmem = (r_state == ST_LOAD) && (r_op == OP_LOAD_DMEM);

   assign cmd_ready   = (r_state == ST_IDLE);
   assign in_ready    = (r_state == ST_LOAD);
   assign out_valid   = (r_state == ST_RD_OUT);
   assign out_last    = out_valid && w_last;
   assign out_data    = r_out_data;
   assign done        = r_done;
   assign err         = r_err;
   assign cpu_enable  = r_cpu_enable;

   assign wen_ext     = w_load_imem && in_valid;
   assign ren_ext     = 1'b0;
   assign addr_ext    = w_load_imem ? w_cur_addr : '0;
   assign wdata_ext   = w_load_imem ? in_data[IDATA_W-1:0] : '0;

   assign wen_ext_2   = w_load_dmem && in_valid;
   assign ren_ext_2   = (r_state == ST_RD_REQ);
   assign addr_ext_2  = (w_load_dmem || ren_ext_2) ? w_cur_addr : '0;
   assign wdata_ext_2 = w_load_dmem ? in_data : '0;

endmodule
